spi_transaction_arbiter: RTL and testbench

// - Shares one half-duplex SPI transaction engine between NUM_REQ fabric-side requesters.
// - Round-robin arbitration; one transaction in flight at a time.
// - Latches the winner's command, issues it to the engine and waits for the engine's read-data response.
// - Routes the read data back to the winning requester. Lives entirely in the fabric_clk domain.

---
 rtl/spi_transaction_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_spi_transaction_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter sharing one SPI transaction engine among NUM_REQ fabric requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_transaction_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            fabric_clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_mask,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic                            spi_cmd_valid,
  input  logic                            spi_cmd_ready,
  output logic [LEN_WIDTH-1:0]            spi_len,
  output logic [DATA_WIDTH-1:0]           spi_data,
  output logic [DATA_WIDTH-1:0]           spi_mask,
  input  logic                            spi_rsp_valid,
  input  logic [DATA_WIDTH-1:0]           spi_rsp_data,
  output logic                            busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  len_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] mask_a;

  assign len_a  = req_len;
  assign data_a = req_data;
  assign mask_a = req_mask;

  state_e                state_q, state_d;
  logic [OW-1:0]         rr_q, rr_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0]         cnt_q, cnt_d;
`endif

  // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
  logic          hit;
  logic [OW-1:0] win;
  int            idx;

  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        win = OW'(idx);
      end
    end
  end

  logic                 len_bad;
  logic [NUM_REQ-1:0]   grant;

  assign len_bad = (len_a[win] == '0) || (32'(len_a[win]) > 32'(DATA_WIDTH));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    len_d       = len_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cmd_valid_d = cmd_valid_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    grant       = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          grant[win] = 1'b1;
          owner_d    = win;
          len_d      = len_a[win];
          data_d     = data_a[win];
          mask_d     = mask_a[win];
          rr_d       = (win == OW'(NUM_REQ-1)) ? '0 : win + OW'(1);
          if (len_bad) begin
            state_d     = RESPOND;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cmd_valid_q && spi_cmd_ready) begin
          state_d     = WAIT;
          cmd_valid_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
        // A response landing on the final count still wins over the abort.
        if (spi_rsp_valid) begin
          state_d     = RESPOND;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = spi_rsp_data;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          state_d     = RESPOND;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        if (spi_rsp_valid) begin
          state_d     = RESPOND;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = spi_rsp_data;
        end
`endif
      end
      RESPOND: begin
        state_d    = IDLE;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cmd_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cmd_valid_q <= cmd_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Grant is combinational from req_valid, so force it low while reset is held.
  assign req_ready = grant & {NUM_REQ{reset_n}};

  always_comb begin
    rsp_valid          = '0;
    rsp_valid[owner_q] = rsp_valid_q;
  end

  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign spi_cmd_valid = cmd_valid_q;
  assign spi_len       = len_q;
  assign spi_data      = data_q;
  assign spi_mask      = mask_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Directed bench for spi_transaction_arbiter: round-robin order, length errors, stall, reset, watchdog.
module tb_spi_transaction_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int TO = 64;

  logic                   fabric_clk = 1'b0;
  logic                   reset_n    = 1'b0;
  logic [NR-1:0]          req_valid  = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][LW-1:0]  req_len    = '0;
  logic [NR-1:0][DW-1:0]  req_data   = '0;
  logic [NR-1:0][DW-1:0]  req_mask   = '0;
  logic [NR-1:0]          rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   spi_cmd_valid;
  logic                   spi_cmd_ready = 1'b0;
  logic [LW-1:0]          spi_len;
  logic [DW-1:0]          spi_data;
  logic [DW-1:0]          spi_mask;
  logic                   spi_rsp_valid = 1'b0;
  logic [DW-1:0]          spi_rsp_data  = '0;
  logic                   busy;

  int n_chk = 0;
  int n_err = 0;

  spi_transaction_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd_ready(spi_cmd_ready),
    .spi_len(spi_len), .spi_data(spi_data), .spi_mask(spi_mask),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_data(spi_rsp_data),
    .busy(busy)
  );

  always #5 fabric_clk = ~fabric_clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge fabric_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d,
                         input logic [DW-1:0] m);
    req_len[i]  = l;
    req_data[i] = d;
    req_mask[i] = m;
  endtask

  // Full transaction from IDLE; engine answers rd after lat quiet WAIT cycles.
  task automatic txn(input int own, input logic [DW-1:0] rd, input int lat, input string tag);
    logic [NR-1:0] oh;
    logic          quiet;
    oh = NR'(1) << own;
    settle();
    chk({tag, "_ready"}, req_ready, oh);
    step();
    settle();
    chk({tag, "_cmd"}, {spi_cmd_valid, busy, spi_len, spi_data, spi_mask},
        {1'b1, 1'b1, req_len[own], req_data[own], req_mask[own]});
    chk({tag, "_nogrant"}, req_ready, 0);
    spi_cmd_ready = 1'b1;
    step();
    spi_cmd_ready = 1'b0;
    quiet = 1'b1;
    repeat (lat) begin
      if (spi_cmd_valid || rsp_valid != 0 || !busy) quiet = 1'b0;
      step();
    end
    chk({tag, "_wait"}, {quiet, spi_cmd_valid}, {1'b1, 1'b0});
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = rd;
    step();
    spi_rsp_valid = 1'b0;
    settle();
    chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_data}, {oh, 1'b0, rd});
    step();
  endtask

  initial begin
    // Reset state, with requests asserted to prove req_ready is held low.
    req_valid = 4'b1111;
    #12;
    chk("rst_outs", {req_ready, rsp_valid, rsp_err, rsp_data, spi_cmd_valid, busy},
        {4'b0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0});
    chk("rst_cmd", {spi_len, spi_data, spi_mask}, 0);
    req_valid = '0;
    step();
    reset_n = 1'b1;
    step();

    // Round robin with all requesters held valid.
    for (int i = 0; i < NR; i++) set_req(i, LW'(8 + i), DW'(32'h1000 + i), DW'(32'hF0 + i));
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) txn(t % NR, DW'(32'hBEEF0000 + t), 1, $sformatf("rr%0d", t));
    req_valid = '0;

    // Single request on 0 with a 10-cycle engine latency.
    set_req(0, 8'd16, 32'hA5A5, 32'hFF00);
    req_valid = 4'b0001;
    settle();
    chk("single_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    settle();
    chk("single_cmd", {spi_cmd_valid, spi_len, spi_data, spi_mask}, {1'b1, 8'd16, 32'hA5A5, 32'hFF00});
    spi_cmd_ready = 1'b1;
    step();
    spi_cmd_ready = 1'b0;
    repeat (10) step();
    chk("single_wait", {rsp_valid, busy, spi_cmd_valid}, {4'b0, 1'b1, 1'b0});
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = 32'h005A;
    step();
    spi_rsp_valid = 1'b0;
    settle();
    chk("single_rsp", {rsp_valid, rsp_err, rsp_data}, {4'b0001, 1'b0, 32'h005A});
    step();
    settle();
    chk("single_done", {rsp_valid, busy}, 0);

    // len=0 on requester 2 (rr pointer now 1).
    set_req(2, 8'd0, 32'h1234, 32'hFFFF);
    req_valid = 4'b0100;
    settle();
    chk("len0_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    settle();
    chk("len0_rsp", {spi_cmd_valid, rsp_valid, rsp_err, rsp_data}, {1'b0, 4'b0100, 1'b1, 32'h0});
    step();
    settle();
    chk("len0_done", {busy, rsp_valid, spi_cmd_valid}, 0);

    // len=33 on requester 1; search 3,0,1.
    set_req(1, 8'd33, 32'h5678, 32'h0);
    req_valid = 4'b0010;
    settle();
    chk("len33_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    settle();
    chk("len33_rsp", {spi_cmd_valid, rsp_valid, rsp_err, rsp_data}, {1'b0, 4'b0010, 1'b1, 32'h0});
    step();

    // len=DATA_WIDTH is legal and reaches the engine.
    set_req(0, 8'd32, 32'hCAFEF00D, 32'hFFFF0000);
    req_valid = 4'b0001;
    txn(0, 32'h0BADC0DE, 0, "len32");
    req_valid = '0;

    // Engine stall of 20 cycles on requester 3 while requester 0 waits.
    set_req(3, 8'd8, 32'h33, 32'h0F);
    req_valid = 4'b1000;
    settle();
    chk("stall_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    repeat (20) begin
      settle();
      chk("stall", {spi_cmd_valid, busy, req_ready, spi_len, spi_data, spi_mask},
          {1'b1, 1'b1, 4'b0, 8'd8, 32'h33, 32'h0F});
      step();
    end
    spi_cmd_ready = 1'b1;
    step();
    spi_cmd_ready = 1'b0;
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = 32'hCAFE;
    step();
    spi_rsp_valid = 1'b0;
    req_valid     = '0;
    settle();
    chk("stall_rsp", {rsp_valid, rsp_err, rsp_data}, {4'b1000, 1'b0, 32'hCAFE});
    step();
    settle();
    chk("drop_nogrant", {busy, req_ready, spi_cmd_valid}, 0);

    // Stray engine response while idle is ignored.
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = 32'h7777;
    step();
    spi_rsp_valid = 1'b0;
    settle();
    chk("stray_rsp", {busy, rsp_valid, rsp_data}, 0);

    // Reset during WAIT on requester 1 (rr would become 2).
    set_req(1, 8'd12, 32'h1111, 32'h2222);
    req_valid = 4'b0010;
    step();
    req_valid     = '0;
    spi_cmd_ready = 1'b1;
    step();
    spi_cmd_ready = 1'b0;
    settle();
    chk("mid_wait", {busy, spi_cmd_valid}, {1'b1, 1'b0});
    reset_n       = 1'b0;
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = 32'h9999;
    settle();
    chk("mid_rst", {busy, spi_cmd_valid, req_ready, rsp_valid, rsp_err, rsp_data, spi_len, spi_data, spi_mask}, 0);
    step();
    reset_n       = 1'b1;
    spi_rsp_valid = 1'b0;
    step();
    settle();
    chk("post_rst", {busy, rsp_valid}, 0);
    set_req(3, 8'd4, 32'h4, 32'h4);
    req_valid = 4'b1010;
    settle();
    chk("post_rst_rr", req_ready, 4'b0010);
    req_valid = 4'b1000;
    settle();
    chk("post_rst_r3", req_ready, 4'b1000);
    step();
    req_valid = '0;
    settle();
    chk("post_rst_cmd", {spi_cmd_valid, spi_len}, {1'b1, 8'd4});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      logic quiet;
      set_req(0, 8'd8, 32'h55, 32'hFF);
      req_valid = 4'b0001;
      step();
      req_valid     = '0;
      spi_cmd_ready = 1'b1;
      step();
      spi_cmd_ready = 1'b0;
      quiet = 1'b1;
      repeat (TO) begin
        if (rsp_valid != 0 || !busy) quiet = 1'b0;
        step();
      end
      settle();
      chk("to_quiet", quiet, 1'b1);
      chk("to_rsp", {rsp_valid, rsp_err, rsp_data}, {4'b0001, 1'b1, 32'h0});
      step();
      spi_rsp_valid = 1'b1;
      spi_rsp_data  = 32'hDEAD;
      step();
      spi_rsp_valid = 1'b0;
      settle();
      chk("to_late", {busy, rsp_valid, rsp_data}, 0);
      step();
      settle();
      chk("to_late2", {busy, rsp_valid}, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
